// File: rtl/flappy_pkg.sv
// Shared types and raster defaults for the Flappy Bird design.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DYING   = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  localparam int DEFAULT_VISIBLE_W = 640;
  localparam int DEFAULT_VISIBLE_H = 480;
  localparam int DEFAULT_GROUND_Y  = 464;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit saturating BCD incrementer with synchronous clear.
module bcd_counter #(
  parameter int SCORE_DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      inc,
  output logic [4*SCORE_DIGITS-1:0] count
);

  logic [4*SCORE_DIGITS-1:0] count_n;
  logic                      carry;
  logic                      all_nines;

  // Ripple the carry up from digit 0; at all-9s the increment is dropped.
  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (count[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
    count_n = count;
    carry   = inc & ~all_nines;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_n[4*i +: 4] = 4'd0;
        end else begin
          count_n[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count_n;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Game sequencer: IDLE/PLAYING/DYING/OVER FSM, frame tick, hit latch and score.
// Optional high-score register enabled by GAME_CONTROLLER_HIGH_SCORE_EN.
module game_controller
  import flappy_pkg::*;
#(
  parameter int SCORE_DIGITS = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int VISIBLE_W    = DEFAULT_VISIBLE_W,
  parameter int VISIBLE_H    = DEFAULT_VISIBLE_H,
  parameter int GROUND_Y     = DEFAULT_GROUND_Y
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flap_btn,
  input  logic [9:0]                hCount,
  input  logic [9:0]                vCount,
  input  logic                      pipe_pixel,
  input  logic                      bird_pixel,
  input  logic                      pipe_passed,
  input  logic [9:0]                bird_y,
  output logic                      pipes_enable,
  output logic                      pipes_reset,
  output logic                      bird_enable,
  output logic                      flap_pulse,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [1:0]                game_state,
  output logic                      game_over
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
  ,
  output logic [4*SCORE_DIGITS-1:0] high_score_bcd
`endif
);

  localparam int DW = $clog2(DEATH_FRAMES + 1);

  game_state_t   state_q, state_n;
  logic          flap_q, origin_q, hit_q;
  logic [DW-1:0] death_cnt;
  logic          flap_edge, at_origin, frame_tick, hit_set, start, score_inc;

  assign flap_edge  = flap_btn & ~flap_q;
  assign at_origin  = (hCount == 10'd0) && (vCount == 10'd0);
  assign frame_tick = at_origin & ~origin_q;
  assign hit_set    = (pipe_pixel & bird_pixel & (int'(hCount) < VISIBLE_W) &
                       (int'(vCount) < VISIBLE_H)) | (int'(bird_y) >= GROUND_Y);
  assign start      = (state_q == IDLE) && flap_edge;
  assign score_inc  = (state_q == PLAYING) && pipe_passed;
  assign game_state = state_q;

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (flap_edge) state_n = PLAYING;
      PLAYING: if (frame_tick && hit_q) state_n = DYING;
      DYING:   if (frame_tick && (death_cnt <= DW'(1))) state_n = OVER;
      OVER:    if (flap_edge) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      flap_q       <= 1'b0;
      origin_q     <= 1'b0;
      hit_q        <= 1'b0;
      death_cnt    <= '0;
      pipes_reset  <= 1'b1;
      pipes_enable <= 1'b0;
      bird_enable  <= 1'b0;
      flap_pulse   <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state_q  <= state_n;
      flap_q   <= flap_btn;
      origin_q <= at_origin;
      // A hit arriving on the tick itself survives to the following tick.
      if (start) hit_q <= 1'b0;
      else if (frame_tick) hit_q <= hit_set;
      else if (hit_set) hit_q <= 1'b1;
      if (state_q == PLAYING && state_n == DYING) begin
        death_cnt <= DW'(DEATH_FRAMES);
      end else if (state_q == DYING && frame_tick && death_cnt != '0) begin
        death_cnt <= death_cnt - DW'(1);
      end
      flap_pulse   <= flap_edge && (state_q == IDLE || state_q == PLAYING);
      pipes_reset  <= (state_n == IDLE);
      pipes_enable <= (state_n == PLAYING);
      bird_enable  <= (state_n == PLAYING) || (state_n == DYING);
      game_over    <= (state_n == OVER);
    end
  end

  bcd_counter #(.SCORE_DIGITS(SCORE_DIGITS)) u_score (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .inc   (score_inc),
    .count (score_bcd)
  );

`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
  logic score_higher, decided;

  // Most significant differing digit decides the comparison.
  always_comb begin
    score_higher = 1'b0;
    decided      = 1'b0;
    for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
      if (!decided && score_bcd[4*i +: 4] != high_score_bcd[4*i +: 4]) begin
        score_higher = score_bcd[4*i +: 4] > high_score_bcd[4*i +: 4];
        decided      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_score_bcd <= '0;
    end else if (state_q == DYING && state_n == OVER && score_higher) begin
      high_score_bcd <= score_bcd;
    end
  end
`endif

endmodule

// File: doc/game_controller.md
# game_controller

Top-level game sequencer for the Flappy Bird design: the consumer side of the pipe renderer's outputs. It owns the IDLE/PLAYING/DYING/OVER state machine and drives the pipe renderer's `enable` and `reset` inputs. It also accumulates pipe-passed pulses into a saturating BCD score and detects bird/pipe pixel overlap during the raster scan. Sits between the pipe renderer, the bird physics block and the score/overlay renderer, all on the single system clock.

## Interface
Parameters:
- `SCORE_DIGITS`, 3: BCD digits in the score.
- `DEATH_FRAMES`, 60: frames spent in DYING before OVER.
- `VISIBLE_W`, 640: visible pixels per line.
- `VISIBLE_H`, 480: visible lines per frame.
- `GROUND_Y`, 464: bird y at or beyond which the bird has hit the ground.

Ports:
- `clk` in 1: system clock. One clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flap_btn` in 1: debounced, synchronized flap button level.
- `hCount` in 10: raster column.
- `vCount` in 10: raster line.
- `pipe_pixel` in 1: current pixel is pipe.
- `bird_pixel` in 1: current pixel is bird.
- `pipe_passed` in 1: one-clk pulse per pipe cleared.
- `bird_y` in 10: bird top y.
- `pipes_enable` out 1: drives pipe renderer `enable`.
- `pipes_reset` out 1: drives pipe renderer `reset`.
- `bird_enable` out 1: bird physics runs.
- `flap_pulse` out 1: one-clk flap command to bird physics.
- `score_bcd` out 4*SCORE_DIGITS: score, digit 0 in bits [3:0].
- `game_state` out 2: IDLE=0, PLAYING=1, DYING=2, OVER=3.
- `game_over` out 1: high in OVER.

## Operation
- **Flap edge:** `flap_btn` is registered once; the edge is `flap_btn & ~flap_q`.
- **Frame tick:** one-clk pulse on the first clk where `hCount==0 && vCount==0` after any clk where that was false. It fires once per frame even though the counters hold for several clocks.
- **Hit latch:**
  - Set when `pipe_pixel & bird_pixel` with `hCount<VISIBLE_W && vCount<VISIBLE_H`.
  - Also set when `bird_y >= GROUND_Y`.
  - Sampled and cleared on the frame tick. A set and a tick in the same clk leave the latch set, carrying the hit to the next tick.
- **IDLE:**
  - `pipes_reset`=1, `pipes_enable`=0, `bird_enable`=0.
  - Flap edge: go to PLAYING, clear score and hit latch, assert `flap_pulse` in that clk.
- **PLAYING:**
  - `pipes_reset`=0, `pipes_enable`=1, `bird_enable`=1.
  - Flap edge: `flap_pulse`.
  - `pipe_passed`: score +1.
  - Frame tick with hit latch set: go to DYING, load the death-frame counter with DEATH_FRAMES.
- **DYING:**
  - `pipes_enable`=0 (pipes freeze), `bird_enable`=1 (bird falls).
  - Flaps ignored.
  - Counter decrements per frame tick; at 0, go to OVER.
- **OVER:**
  - `pipes_enable`=0, `bird_enable`=0, `game_over`=1.
  - Flap edge: go to IDLE, no `flap_pulse`.
- **Score:**
  - `SCORE_DIGITS`-digit BCD, ripple carry.
  - Saturates at all-9s; further pulses are ignored.
  - `pipe_passed` counts only in PLAYING; a pulse in the same clk as the transition to DYING still counts.

## Timing
- Reset values: `game_state`=IDLE, `pipes_reset`=1, `pipes_enable`=0, `bird_enable`=0, `flap_pulse`=0, `score_bcd`=0, `game_over`=0, hit latch 0, `flap_q`=0.
- All outputs are registered.
- `flap_btn` rise at clk N: `flap_pulse` and state change visible after edge N+1.
- `pipe_passed` at clk N: `score_bcd` updated after edge N+1.
- Frame tick at clk N with hit: `game_state`=DYING and `pipes_enable`=0 after edge N+1.
- DYING lasts exactly DEATH_FRAMES frame ticks.
- Reset mid-game: all state asynchronously returns to reset values, including score.
- Simultaneous flap edge and hit tick in PLAYING: `flap_pulse` is emitted and the state still goes to DYING.

## Configuration
- Macro `GAME_CONTROLLER_HIGH_SCORE_EN`.
- **Defined:**
  - Adds output `high_score_bcd` (4*SCORE_DIGITS), reset to 0.
  - On the DYING→OVER transition, loads `score_bcd` if it is greater; BCD compare is most significant digit first.
  - Survives IDLE/PLAYING cycles; cleared only by `reset`.
- **Undefined:** port and register absent; behaviour otherwise identical.

## Structure
- Shared package `flappy_pkg`:
  - `game_state_t` enum (IDLE/PLAYING/DYING/OVER, 2-bit).
  - `VISIBLE_W`, `VISIBLE_H`, `GROUND_Y` defaults.
- Sub-module `bcd_counter`: parameterized `SCORE_DIGITS` saturating incrementer with synchronous clear and async reset. Used for the score.
- FSM, frame-tick detector and hit latch stay in `game_controller`.

## Test plan
- **Reset, idle hold:** reset, then 1000 clks idle → `game_state`=0, `pipes_reset`=1, `pipes_enable`=0, `score_bcd`=0.
- **Start:** flap_btn 0→1 in IDLE → `flap_pulse` for exactly 1 clk, `game_state`=1, `pipes_reset`=0, `pipes_enable`=1 one clk later. Holding `flap_btn` high gives no further pulses.
- **Scoring, saturation:** 12 `pipe_passed` pulses in PLAYING → `score_bcd`=12'h012. Preload to 999, one more pulse → stays 12'h999.
- **Pixel collision:** `pipe_pixel`=`bird_pixel`=1 at hCount=100, vCount=200 → next frame tick moves to DYING. The same overlap at hCount=700 → no transition.
- **Ground hit, death timing:**
  - `bird_y`=464 → DYING at the next tick, OVER after exactly 60 further frame ticks, `game_over`=1.
  - Flap in OVER → IDLE with no `flap_pulse`.
- **Async reset in DYING:** `reset` pulsed mid-clock → outputs return to reset values immediately. With `GAME_CONTROLLER_HIGH_SCORE_EN`, score 7 then score 5 games → `high_score_bcd`=12'h007.
